// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Accepts a length-prefixed, big-endian byte stream over valid/ready,
// assembles WORD_W-bit words and writes them to addresses 0..N-1.
// Holds the core in reset (cpu_hold) for the duration of a load.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match before the load is reported done.
module imem_loader #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    localparam int BPW    = WORD_W / 8;
    localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BPW - 1);
    localparam logic [31:0]       DEPTH     = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [7:0]          csum_q, csum_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                in_load;
    logic                accept;
    logic [31:0]         len_full;
    logic [WORD_W-1:0]   asm_next;
    logic [CNT_W-1:0]    word_inc;

    // States in which the loader owns the stream and holds the core.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_load = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
`else
    assign in_load = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA);
`endif

    assign accept   = rx_valid && in_load;
    assign len_full = {16'd0, len_hi_q, rx_data};
    // Big-endian assembly: earlier bytes end up in the upper bits.
    assign asm_next = (asm_q << 8) | WORD_W'(rx_data);
    assign word_inc = word_cnt_q + CNT_W'(1);

    // Next-state and registered-output computation for the load FSM.
    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                    asm_d      = '0;
                end
            end

            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    csum_d   = csum_q ^ rx_data;
                    state_d  = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    if (len_full > DEPTH) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else if (len_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        len_d   = CNT_W'(len_full);
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    asm_d  = asm_next;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                        wr_data_d  = asm_next;
                        word_cnt_d = word_inc;
                        if (word_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    end
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rx_ready = in_load;
    assign busy     = in_load;
    assign cpu_hold = in_load;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized streams against a stream-level
// reference model, with a write/status scoreboard checked by a monitor.
module tb_imem_loader;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 4;
    localparam int BPW    = WORD_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;

    imem_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                tag;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_exp_t;

    typedef struct {
        int   tag;
        logic busy;
        logic done;
        logic error;
        bit   zero_wr;
        bit   wq_empty;
    } st_exp_t;

    wr_exp_t           wq[$];
    st_exp_t           sq[$];
    logic [WORD_W-1:0] words [DEPTH];
    bit                spacing_on;
    int                n_cmp;
    int                n_fail;

    task automatic chk(input string name, input int tag,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s tag=%0d actual=%0h required=%0h", name, tag, act, exp);
        end
    endtask

    // Monitor: pops expected writes on each strobe and expected status words.
    initial begin
        wr_exp_t we;
        st_exp_t s;
        int      cyc;
        int      prev;
        cyc    = 0;
        prev   = 0;
        n_cmp  = 0;
        n_fail = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (wr_en === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("wr_en_unexpected", 0, 64'(wr_en), 64'd0);
                end else begin
                    we = wq.pop_front();
                    chk("wr_addr", we.tag, 64'(wr_addr), 64'(we.addr));
                    chk("wr_data", we.tag, 64'(wr_data), 64'(we.data));
                    if (spacing_on && wr_addr != '0)
                        chk("wr_spacing", we.tag, 64'(cyc - prev), 64'(BPW));
                end
                prev = cyc;
            end
            while (sq.size() > 0) begin
                s = sq.pop_front();
                chk("busy",     s.tag, 64'(busy),     64'(s.busy));
                chk("rx_ready", s.tag, 64'(rx_ready), 64'(s.busy));
                chk("cpu_hold", s.tag, 64'(cpu_hold), 64'(s.busy));
                chk("done",     s.tag, 64'(done),     64'(s.done));
                chk("error",    s.tag, 64'(error),    64'(s.error));
                if (s.zero_wr) begin
                    chk("rst_wr_en",   s.tag, 64'(wr_en),   64'd0);
                    chk("rst_wr_addr", s.tag, 64'(wr_addr), 64'd0);
                    chk("rst_wr_data", s.tag, 64'(wr_data), 64'd0);
                end
                if (s.wq_empty)
                    chk("writes_outstanding", s.tag, 64'(wq.size()), 64'd0);
            end
        end
    end

    task automatic push_st(input int tag, input logic b, input logic d,
                           input logic e, input bit zw, input bit wqe);
        st_exp_t s;
        s.tag = tag; s.busy = b; s.done = d; s.error = e;
        s.zero_wr = zw; s.wq_empty = wqe;
        sq.push_back(s);
    endtask

    // Called at negedge time; returns at the posedge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input bit rv);
        bit ok;
        bit r;
        if (rv && ($urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            r = rx_ready;
            @(posedge clk);
            if (r) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            $display("FAIL byte_accept_timeout actual=no_accept required=accept");
            $fatal(1, "byte never accepted");
        end
    endtask

    task automatic do_start(input int tag);
        start = 1'b1;
        @(posedge clk);
        push_st(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference model: stream bytes and writes derived from length + words.
    task automatic run_load(input int tag, input int n, input bit rv,
                            input bit bad_csum, input bit mid_start);
        logic [7:0]  q[$];
        logic [15:0] nn;
        logic [7:0]  cs;
        bit          err;
        int          nw;
        int          di;
        wr_exp_t     we;
        nn  = n[15:0];
        err = (n > DEPTH);
        nw  = err ? 0 : n;
        q.push_back(nn[15:8]);
        q.push_back(nn[7:0]);
        for (int w = 0; w < nw; w++)
            for (int b = 0; b < BPW; b++)
                q.push_back(words[w][WORD_W-1-8*b -: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!err) begin
            cs = 8'd0;
            foreach (q[i]) cs = cs ^ q[i];
            if (bad_csum) cs = cs + 8'd1;
            err = bad_csum;
            q.push_back(cs);
        end
`else
        cs = 8'd0;
        if (bad_csum) cs = 8'd1;
`endif
        spacing_on = !rv;
        do_start(tag);
        for (int i = 0; i < q.size(); i++) begin
            di = i - 2;
            if (di >= 0 && di < nw * BPW && (di % BPW) == BPW - 1) begin
                we.tag  = tag;
                we.addr = ADDR_W'(di / BPW);
                we.data = words[di / BPW];
                wq.push_back(we);
            end
            if (mid_start && i == 3) start = 1'b1;
            send_byte(q[i], rv);
            if (i == q.size() - 1)
                push_st(tag, 1'b0, !err, err, 1'b0, 1'b1);
            @(negedge clk);
            start    = 1'b0;
            rx_valid = 1'b0;
        end
        // Bytes offered after completion must be ignored.
        repeat (4) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        @(posedge clk);
        push_st(tag, 1'b0, !err, err, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        rx_data    = 8'd0;
        rx_valid   = 1'b0;
        spacing_on = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        push_st(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        run_load(2, 2, 1'b0, 1'b0, 1'b0);
        run_load(3, 2, 1'b1, 1'b0, 1'b0);
        run_load(4, 17, 1'b0, 1'b0, 1'b0);
        run_load(5, 16'h0100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        run_load(6, 16, 1'b0, 1'b0, 1'b0);
        run_load(7, 0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of the data phase, then reload cleanly.
        words[0] = 32'h11223344;
        words[1] = 32'h55667788;
        do_start(8);
        send_byte(8'h00, 1'b0); @(negedge clk);
        send_byte(8'h02, 1'b0); @(negedge clk);
        send_byte(8'h11, 1'b0); @(negedge clk);
        send_byte(8'h22, 1'b0); @(negedge clk);
        send_byte(8'h33, 1'b0); @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        push_st(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run_load(9, 2, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = 32'hDEADBEEF;
        run_load(10, 1, 1'b0, 1'b0, 1'b0);
        run_load(11, 1, 1'b0, 1'b1, 1'b0);
        run_load(12, 0, 1'b1, 1'b1, 1'b0);
`endif

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
            n = $urandom_range(0, DEPTH + 1);
            run_load(20 + t, n, 1'($urandom_range(0, 1)),
`ifdef IMEM_LOADER_CHECKSUM_EN
                     1'($urandom_range(0, 3) == 0),
`else
                     1'b0,
`endif
                     1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
